// File: rtl/prio_enc_scan_pkg.sv
// Shared seven-segment constants for the board display blocks.
// Segments are active-low, bit 0 = a through bit 6 = g.
package prio_enc_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/prio_enc_scan_seg7_hex.sv
// Combinational 4-bit to active-low seven-segment hex decoder.
// Zero latency; no flow control.
module seg7_hex
    import prio_enc_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/prio_enc_scan.sv
// Registered priority encoder with change pulse, hold and scanned hex display.
// Latency: two cycles from x/en to idx/valid; no backpressure, hold freezes the result.
module prio_enc_scan
    import prio_enc_scan_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000,
    localparam int IDX_W   = $clog2(IN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   x,
    input  logic              en,
    input  logic              hold,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic              changed,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

    logic [IN_W-1:0]     x_q;
    logic                en_q;
    logic                v;
    logic [IDX_W-1:0]    i;
    logic [CNT_W-1:0]    cnt;
    logic [DIG_W-1:0]    dig;
    logic [DIGITS*4-1:0] idx_ext;
    logic [3:0]          nib;
    logic [6:0]          hex_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            en_q <= 1'b0;
        end else begin
            x_q  <= x;
            en_q <= en;
        end
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        v = en_q && (x_q != '0);
        i = '0;
        if (v) begin
            for (int b = 0; b < IN_W; b++) begin
                if (x_q[b]) i = IDX_W'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else if (hold) begin
            changed <= 1'b0;
        end else begin
            idx     <= i;
            valid   <= v;
            changed <= ({v, i} != {valid, idx});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dig <= '0;
        end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
            cnt <= '0;
            dig <= (dig == DIG_W'(DIGITS - 1)) ? '0 : dig + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign idx_ext = (DIGITS*4)'(idx);
    assign nib     = idx_ext[dig*4 +: 4];

    seg7_hex u_hex (
        .nib (nib),
        .seg (hex_seg)
    );

    // Digit select and segments come from the same digit index so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_RST;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(DIGITS'(1) << dig);
            seg <= valid ? hex_seg : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed bench for prio_enc_scan with IN_W=16, DIGITS=2, SCAN_DIV=4.
module tb_prio_enc_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] x;
    logic        en;
    logic        hold;
    logic [3:0]  idx;
    logic        valid;
    logic        changed;
    logic [1:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    prio_enc_scan #(.IN_W(16), .DIGITS(2), .SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x       (x),
        .en      (en),
        .hold    (hold),
        .idx     (idx),
        .valid   (valid),
        .changed (changed),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Walk two full scan rounds and check the segments shown on each digit.
    task automatic check_disp(input string tag, input logic [6:0] d0, input logic [6:0] d1);
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (an == 2'b10) check({tag, "_d0"}, seg, d0);
            else if (an == 2'b01) check({tag, "_d1"}, seg, d1);
            else check({tag, "_an"}, an, 2'b10);
        end
    endtask

    logic [1:0] an_seq [9];

    initial begin
        an_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        rst_n = 1'b0;
        x     = '0;
        en    = 1'b0;
        hold  = 1'b0;
        step(2);
        check("rst_idx", idx, 0);
        check("rst_valid", valid, 0);
        check("rst_changed", changed, 0);
        check("rst_an", an, 2'b10);
        check("rst_seg", seg, 7'h7F);
        rst_n = 1'b1;
        step(2);

        // Encode 0x8421 -> 15
        x = 16'h8421; en = 1'b1;
        step(1);
        check("enc_lat1_valid", valid, 0);
        step(1);
        check("enc_idx", idx, 15);
        check("enc_valid", valid, 1);
        check("enc_changed", changed, 1);
        step(1);
        check("enc_changed_clr", changed, 0);
        check_disp("enc_disp", 7'b0001110, 7'b1000000);

        // Edge values
        x = 16'h0001;
        step(2);
        check("x0001_idx", idx, 0);
        check("x0001_valid", valid, 1);
        x = 16'h0020;
        step(2);
        check("x0020_idx", idx, 5);
        check_disp("x0020_disp", 7'b0010010, 7'b1000000);
        x = 16'h0400;
        step(2);
        check("x0400_idx", idx, 10);
        check_disp("x0400_disp", 7'b0001000, 7'b1000000);
        x = 16'h0000;
        step(2);
        check("x0_valid", valid, 0);
        check("x0_idx", idx, 0);
        check("x0_changed", changed, 1);
        step(1);
        check("x0_changed_clr", changed, 0);
        check_disp("x0_disp", 7'h7F, 7'h7F);

        // Enable gating
        x = 16'hFFFF; en = 1'b0;
        step(2);
        check("en0_valid", valid, 0);
        check("en0_idx", idx, 0);
        check("en0_changed", changed, 0);
        en = 1'b1;
        step(1);
        check("en1_lat1_valid", valid, 0);
        step(1);
        check("en1_idx", idx, 15);
        check("en1_valid", valid, 1);
        check("en1_changed", changed, 1);

        // Hold
        x = 16'h0020;
        step(3);
        check("pre_hold_idx", idx, 5);
        hold = 1'b1; x = 16'h0400;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("hold_idx", idx, 5);
            check("hold_changed", changed, 0);
        end
        hold = 1'b0;
        step(1);
        check("unhold_idx", idx, 10);
        check("unhold_changed", changed, 1);

        // Steady input
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("steady_changed", changed, 0);
        end
        check("steady_idx", idx, 10);

        // Asynchronous reset mid-operation with hold asserted
        hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_idx", idx, 0);
        check("arst_valid", valid, 0);
        check("arst_changed", changed, 0);
        check("arst_an", an, 2'b10);
        check("arst_seg", seg, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        hold  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step(1);
            check("arst_an_seq", an, an_seq[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prio_enc_scan.md
Name: prio_enc_scan

Overview:
- Parametrised, registered successor of the 8-to-3 priority encoder with seven-segment output.
- Captures an IN_W-bit request vector and encodes the highest set bit.
- Provides a valid flag, a one-cycle change pulse and a hold (freeze) mode.
- Drives a time-multiplexed multi-digit hex seven-segment display for the board I/O layer.

Parameters:
- IN_W, 16: request vector width; must be ≥2.
- DIGITS, 2: number of scanned hex digits; DIGITS*4 ≥ IDX_W, where IDX_W = $clog2(IN_W).
- SCAN_DIV, 1000: clock cycles each digit stays selected; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- x  input  IN_W  request vector.
- en  input  1  encoder enable.
- hold  input  1  freeze the encoded result while high.
- idx  output  IDX_W  index of the highest set bit of x.
- valid  output  1  high when en was 1 and x was nonzero.
- changed  output  1  one-cycle pulse when {valid, idx} updates to a different value.
- an  output  DIGITS  digit select, one-hot, active-low.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Reset (rst_n=0, async assert; deassert sampled at clk):
  - idx=0, valid=0, changed=0.
  - x_q=0, en_q=0.
  - Scan counter=0, digit index=0, so an = ~(1<<0).
  - seg=7'h7F (blank).
  - Reset mid-operation behaves identically, regardless of hold.
- Stage 1: x_q<=x and en_q<=en on every clk edge. Not affected by hold.
- Stage 2 (result register), combinational from x_q/en_q:
  - v = en_q && (x_q != 0).
  - i = highest set bit index of x_q when v, else 0.
  - When hold=0: {valid,idx} <= {v,i}.
  - When hold=1: {valid,idx} keep their value.
- Latency: x/en sampled at edge k appear on idx/valid after edge k+1, i.e. two cycles.
- changed:
  - Registered; goes to 1 on the edge where stage 2 loads a {v,i} that differs from the current {valid,idx}.
  - 0 otherwise, and always 0 while hold=1.
  - Hold released while the input differs: update and changed occur at the first edge with hold=0.
- Invalid vs index 0:
  - x=1, en=1 gives idx=0, valid=1.
  - x=0 or en=0 gives idx=0, valid=0.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - At wrap, the digit index advances 0..DIGITS-1 and wraps to 0.
  - SCAN_DIV=1 advances the digit every cycle.
- an = ~(1 << digit index), registered together with seg.
- Digit d shows nibble d of idx zero-extended to DIGITS*4 bits; digit 0 is the least significant nibble.
- seg when valid=0: 7'h7F on every digit (blank).
- Hex encoding (active-low), values used below:
  - 0 = 7'b1000000
  - 5 = 7'b0010010
  - A = 7'b0001000
  - F = 7'b0001110
- an/seg lag the digit index by one register stage and always change on the same edge.
- hold does not stop scanning.

Decomposition:
- Shared package:
  - Seven-segment hex constants SEG_0..SEG_F.
  - SEG_BLANK = 7'h7F.
  - A clog2 helper, if the tool flow needs one.
- Sub-module seg7_hex: 4-bit to 7-bit active-low combinational decoder, reused by other display blocks.
- Encoder and scan logic stay in prio_enc_scan.

Test Plan (IN_W=16, DIGITS=2, SCAN_DIV=4):
- Reset:
  - Stimulus: pulse rst_n low asynchronously between edges, while valid=1.
  - Required: outputs clear immediately to idx=0, valid=0, changed=0, an=2'b10, seg=7'h7F.
  - Required after release: an sequence 10,10,10,10,01,01,01,01,10.
- Encode:
  - Stimulus: x=16'h8421, en=1 from cycle 0.
  - Required: idx=15 and valid=1 after the second edge; changed=1 for exactly one cycle.
  - Required display: seg=F (7'b0001110) while an=2'b10; seg=0 (7'b1000000) while an=2'b01.
- Edge values:
  - x=16'h0001 → idx=0, valid=1.
  - x=16'h0020 → idx=5, seg 7'b0010010 on digit 0.
  - x=16'h0400 → idx=10, seg 7'b0001000 on digit 0.
  - x=0 → valid=0, idx=0, seg=7'h7F on both digits, changed pulses once.
- Enable:
  - Stimulus: x=16'hFFFF, en=0.
  - Required: valid=0, idx=0.
  - Stimulus: set en=1.
  - Required: two cycles later idx=15, valid=1, changed pulse.
- Hold:
  - Stimulus: with idx=5 valid, set hold=1 and change x to 16'h0400.
  - Required: idx stays 5 and changed stays 0 for 10 cycles.
  - Stimulus: drop hold.
  - Required: at the next edge idx=10 and changed=1 for one cycle.
- Steady input:
  - Stimulus: same x held for 20 cycles.
  - Required: changed stays 0 after the initial pulse.
